// File: rtl/expmul_pipe_if.sv
// Valid/ready handshake bundle for expmul_pipe: one score pair plus N packed lanes in,
// N packed scaled lanes out.
interface expmul_pipe_if #(
  parameter int N  = 8,
  parameter int DW = 16
);
  logic            vld_in;
  logic            rdy_out;
  logic            vld_out;
  logic            rdy_in;
  logic [DW-1:0]   a_in;
  logic [DW-1:0]   b_in;
  logic [N*DW-1:0] v_in;
  logic [N*DW-1:0] v_out;

  // master is the upstream producer and downstream consumer side; slave is the block
  modport master (
    output vld_in, a_in, b_in, v_in, rdy_in,
    input  rdy_out, vld_out, v_out
  );

  modport slave (
    input  vld_in, a_in, b_in, v_in, rdy_in,
    output rdy_out, vld_out, v_out
  );
endinterface

// File: rtl/expmul_pipe.sv
// Three-stage pipeline scaling N signed lanes by a base-2 approximation of exp(a - b),
// with a single global advance enable shared by all stages.
module expmul_pipe #(
  parameter int N       = 8,
  parameter int DW      = 16,
  parameter int FRAC    = 8,
  parameter int LOG2E_Q = 369
) (
  input  logic         clk,
  input  logic         rst,
  expmul_pipe_if.slave bus
);

  localparam int LW = $clog2(LOG2E_Q + 1) + 1;
  localparam int PW = DW + 1 + LW;
  localparam int IW = PW - FRAC;
  localparam int SW = FRAC + 1;
  localparam int MW = DW + SW + 1;
  localparam logic signed [LW-1:0] LOG2E = LW'(LOG2E_Q);

  logic            en;
  logic            s1_vld;
  logic [PW-1:0]   s1_u;
  logic [N*DW-1:0] s1_v;
  logic            s2_vld;
  logic [SW-1:0]   s2_scale;
  logic [N*DW-1:0] s2_v;
  logic            out_vld;
  logic [N*DW-1:0] out_v;

  assign en          = !out_vld || bus.rdy_in;
  assign bus.rdy_out = en;
  assign bus.vld_out = out_vld;
  assign bus.v_out   = out_v;

  logic signed [DW:0]   d;
  logic signed [DW:0]   d_neg;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] u;

  // Positive differences saturate to exp(0) = 1.0, so u is never positive
  assign d     = {bus.a_in[DW-1], bus.a_in} - {bus.b_in[DW-1], bus.b_in};
  assign d_neg = d[DW] ? d : '0;
  assign prod  = PW'(d_neg) * PW'(LOG2E);
  assign u     = prod >>> FRAC;

  logic signed [IW-1:0] ip;
  logic [IW-1:0]        neg_ip;
  logic [FRAC-1:0]      fp;
  logic [SW-1:0]        scale;

  assign ip     = s1_u[PW-1:FRAC];
  assign fp     = s1_u[FRAC-1:0];
  assign neg_ip = -ip;

  // 2^u = 2^ip * (1 + fp/2^FRAC); shifts beyond the mantissa width flush to zero
  always_comb begin
    scale = '0;
    if (neg_ip <= IW'(FRAC + 1)) begin
      scale = {1'b1, fp} >> neg_ip;
    end
  end

  logic [N*DW-1:0]      v_next;
  logic signed [MW-1:0] scale_ext;

  assign scale_ext = {{(MW-SW){1'b0}}, s2_scale};

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic signed [DW-1:0] lane;
    logic signed [MW-1:0] lane_ext;
    logic signed [MW-1:0] lane_prod;

    assign lane      = s2_v[g*DW +: DW];
    assign lane_ext  = {{(MW-DW){lane[DW-1]}}, lane};
    assign lane_prod = lane_ext * scale_ext;
    assign v_next[g*DW +: DW] = lane_prod[FRAC +: DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_u     <= '0;
      s1_v     <= '0;
      s2_vld   <= 1'b0;
      s2_scale <= '0;
      s2_v     <= '0;
      out_vld  <= 1'b0;
      out_v    <= '0;
    end else if (en) begin
      s1_vld   <= bus.vld_in;
      s1_u     <= u;
      s1_v     <= bus.v_in;
      s2_vld   <= s1_vld;
      s2_scale <= scale;
      s2_v     <= s1_v;
      out_vld  <= s2_vld;
      out_v    <= v_next;
    end
  end

endmodule

// File: tb/tb_expmul_pipe.sv
// Self-checking bench for expmul_pipe: directed spec vectors plus randomized traffic
// scored against an integer reference model of the exp-scale rules.
module tb_expmul_pipe;

  localparam int N       = 8;
  localparam int DW      = 16;
  localparam int FRAC    = 8;
  localparam int LOG2E_Q = 369;
  localparam int VW      = N * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  expmul_pipe_if #(.N(N), .DW(DW)) bus ();

  expmul_pipe #(.N(N), .DW(DW), .FRAC(FRAC), .LOG2E_Q(LOG2E_Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_out   = 0;
  logic [VW-1:0] exp_q[$];

  // Reference: exp(d) ~= 2^(d*log2e) with integer floor arithmetic on the real values
  function automatic logic [VW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [VW-1:0] v);
    int d, u, ip, fp, sc, lane, r;
    logic [VW-1:0] res;
    d = int'($signed(a)) - int'($signed(b));
    if (d > 0) d = 0;
    u  = (d * LOG2E_Q) >>> FRAC;
    ip = u >>> FRAC;
    fp = u - ip * (2 ** FRAC);
    if (-ip > FRAC + 1) sc = 0;
    else sc = (2 ** FRAC + fp) >> (-ip);
    res = '0;
    for (int i = 0; i < N; i++) begin
      lane = int'($signed(v[i*DW +: DW]));
      r    = (lane * sc) >>> FRAC;
      res[i*DW +: DW] = r[DW-1:0];
    end
    return res;
  endfunction

  function automatic logic [VW-1:0] rand_v();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic rand_ab(output logic [DW-1:0] a, output logic [DW-1:0] b);
    b = DW'($urandom_range(0, 1024));
    if ($urandom_range(0, 7) == 0) a = b + DW'($urandom_range(1, 255));
    else a = b - DW'($urandom_range(0, 2560));
  endtask

  task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_output();
    n_tests++;
    assert (bus.rdy_out === (!bus.vld_out || bus.rdy_in)) else begin
      n_fail++;
      $error("[TB] FAIL rdy_out: observed %b expected %b", bus.rdy_out, !bus.vld_out || bus.rdy_in);
    end
    if (rst) begin
      exp_q.delete();
      return;
    end
    if (bus.vld_out === 1'b1) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("[TB] FAIL spurious_output: observed vld_out=1 v_out=%h expected no result", bus.v_out);
      end
      if (exp_q.size() != 0) begin
        check_val("v_out", bus.v_out, exp_q[0]);
        if (bus.rdy_in) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  endtask

  // One clock: score outputs and record accepts mid-cycle, then return just after the edge
  task automatic tick();
    @(negedge clk);
    check_output();
    if (!rst && bus.vld_in && bus.rdy_out) begin
      exp_q.push_back(model(bus.a_in, bus.b_in, bus.v_in));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic vld, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [VW-1:0] v, input logic rdy);
    bus.vld_in = vld;
    bus.a_in   = a;
    bus.b_in   = b;
    bus.v_in   = v;
    bus.rdy_in = rdy;
    tick();
  endtask

  task automatic run_single(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [VW-1:0] v, input logic [VW-1:0] want);
    int lat;
    apply_stimulus(1'b1, a, b, v, 1'b1);
    lat = 1;
    while (bus.vld_out !== 1'b1 && lat < 10) begin
      apply_stimulus(1'b0, '0, '0, '0, 1'b1);
      lat++;
    end
    check_val({tag, "_latency"}, VW'(lat), VW'(3));
    check_val(tag, bus.v_out, want);
    apply_stimulus(1'b0, '0, '0, '0, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    logic [VW-1:0] v;
    logic vld, rdy;
    int k, acc0, out0;

    bus.vld_in = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.v_in   = '0;
    bus.rdy_in = 1'b1;
    rst        = 1'b1;
    @(posedge clk);
    #1;

    // Reset holds off even a valid input presented at the same time
    apply_stimulus(1'b1, 16'h0100, 16'h0100, rand_v(), 1'b1);
    apply_stimulus(1'b1, 16'h0100, 16'h0100, rand_v(), 1'b1);
    bus.vld_in = 1'b0;
    rst        = 1'b0;
    check_val("reset_vld_out", VW'(bus.vld_out), '0);
    check_val("reset_v_out", bus.v_out, '0);
    check_val("reset_rdy_out", VW'(bus.rdy_out), VW'(1));
    repeat (4) apply_stimulus(1'b0, '0, '0, '0, 1'b1);

    run_single("unity", 16'h0100, 16'h0100, {N{16'h0100}}, {N{16'h0100}});
    run_single("minus_one", 16'h0000, 16'h0100,
               {{((N-2)*DW){1'b0}}, 16'hFF00, 16'h0100},
               {{((N-2)*DW){1'b0}}, 16'hFF9D, 16'h0063});
    v = rand_v();
    run_single("clamp", 16'h0164, 16'h0100, v, v);
    run_single("underflow", 16'h0000, 16'h1000, rand_v(), '0);

    // Ten back-to-back transactions against a 1,0,0,1 downstream ready pattern
    acc0 = n_acc;
    out0 = n_out;
    k    = 0;
    while ((n_acc - acc0 < 10 || exp_q.size() != 0) && k < 300) begin
      rdy = (k % 4 == 0) || (k % 4 == 3);
      vld = (n_acc - acc0 < 10);
      rand_ab(a, b);
      apply_stimulus(vld, a, b, rand_v(), rdy);
      k++;
    end
    check_val("burst_accepted", VW'(n_acc - acc0), VW'(10));
    check_val("burst_emitted", VW'(n_out - out0), VW'(10));

    // Random valid/ready traffic, then drain
    for (int i = 0; i < 80; i++) begin
      rand_ab(a, b);
      apply_stimulus(1'($urandom_range(0, 1)), a, b, rand_v(), 1'($urandom_range(0, 1)));
    end
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      apply_stimulus(1'b0, '0, '0, '0, 1'b1);
      k++;
    end
    check_val("random_drained", VW'(exp_q.size()), '0);

    // Reset with two transactions in flight discards both
    rand_ab(a, b);
    apply_stimulus(1'b1, a, b, rand_v(), 1'b1);
    rand_ab(a, b);
    apply_stimulus(1'b1, a, b, rand_v(), 1'b1);
    rst = 1'b1;
    apply_stimulus(1'b1, a, b, rand_v(), 1'b1);
    rst        = 1'b0;
    bus.vld_in = 1'b0;
    check_val("midrst_vld_out", VW'(bus.vld_out), '0);
    repeat (5) apply_stimulus(1'b0, '0, '0, '0, 1'b1);
    rand_ab(a, b);
    v = rand_v();
    run_single("post_reset", a, b, v, model(a, b, v));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
